// File: rtl/jk_ff_bank.sv
// jk_ff_bank: WIDTH-bit bank of flip-flops with JK/SR/T/D modes,
// parallel load, sticky illegal-SR flag and saturating change counter.
module jk_ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             q_chg,
    output logic [CNT_W-1:0] chg_cnt,
    output logic             sr_err
);

    localparam logic [1:0] M_JK = 2'b00;
    localparam logic [1:0] M_SR = 2'b01;
    localparam logic [1:0] M_T  = 2'b10;
    localparam logic [1:0] M_D  = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic             sr_set;
    logic             chg;
    logic             cnt_sat;

    always_comb begin
        q_next = Q;
        sr_set = 1'b0;
        if (load) begin
            q_next = load_val;
        end else if (en) begin
            unique case (mode)
                M_JK: q_next = (J & ~Q) | (~K & Q);
                // S=R=1 holds: only a pure S sets and a pure R clears
                M_SR: begin
                    q_next = (J & ~K) | (Q & ~(~J & K));
                    sr_set = |(J & K);
                end
                M_T:  q_next = Q ^ J;
                M_D:  q_next = J;
                default: q_next = Q;
            endcase
        end
    end

    assign chg     = (q_next != Q);
    assign cnt_sat = &chg_cnt;
    assign Qn      = ~Q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Q       <= RESET_VAL;
            q_chg   <= 1'b0;
            chg_cnt <= '0;
            sr_err  <= 1'b0;
        end else begin
            Q      <= q_next;
            q_chg  <= chg;
            sr_err <= sr_set | (sr_err & ~clr);
            if (clr) begin
                chg_cnt <= {{(CNT_W-1){1'b0}}, chg};
            end else if (chg && !cnt_sat) begin
                chg_cnt <= chg_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb_jk_ff_bank: directed vectors with a per-bit behavioural model
// checked every cycle, plus literal expectations from the test plan.
module tb_jk_ff_bank;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;
    localparam int         CW = 2;
    localparam int         CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [W-1:0]  j = '0;
    logic [W-1:0]  k = '0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic          clr = 1'b0;
    logic [W-1:0]  q;
    logic [W-1:0]  qn;
    logic          q_chg;
    logic [CW-1:0] chg_cnt;
    logic          sr_err;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [W-1:0] mq;
    logic         mchg;
    int           mcnt;
    logic         merr;

    jk_ff_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .J(j), .K(k), .load(load), .load_val(load_val),
        .clr(clr), .Q(q), .Qn(qn), .q_chg(q_chg),
        .chg_cnt(chg_cnt), .sr_err(sr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        logic [W-1:0] nq;
        logic         bad;
        logic         c;
        if (!rst) begin
            mq = RV;
            mchg = 1'b0;
            mcnt = 0;
            merr = 1'b0;
        end else begin
            nq = mq;
            bad = 1'b0;
            if (load) begin
                nq = load_val;
            end else if (en) begin
                for (int i = 0; i < W; i++) begin
                    case (mode)
                        2'd0: begin
                            if (j[i] && k[i]) nq[i] = ~mq[i];
                            else if (j[i]) nq[i] = 1'b1;
                            else if (k[i]) nq[i] = 1'b0;
                        end
                        2'd1: begin
                            if (j[i] && k[i]) bad = 1'b1;
                            else if (j[i]) nq[i] = 1'b1;
                            else if (k[i]) nq[i] = 1'b0;
                        end
                        2'd2: if (j[i]) nq[i] = ~mq[i];
                        default: nq[i] = j[i];
                    endcase
                end
            end
            c = (nq != mq);
            if (clr) mcnt = c ? 1 : 0;
            else if (c) mcnt = (mcnt + 1 > CMAX) ? CMAX : mcnt + 1;
            merr = bad || (merr && !clr);
            mchg = c;
            mq = nq;
        end
    end

    always @(negedge clk) begin
        if (armed && rst) begin
            checks += 5;
            if (q !== mq) begin
                errors++;
                $display("FAIL model_q t=%0t got %b want %b", $time, q, mq);
            end
            if (qn !== ~mq) begin
                errors++;
                $display("FAIL model_qn t=%0t got %b want %b", $time, qn, ~mq);
            end
            if (q_chg !== mchg) begin
                errors++;
                $display("FAIL model_qchg t=%0t got %b want %b", $time, q_chg, mchg);
            end
            if (chg_cnt !== CW'(mcnt)) begin
                errors++;
                $display("FAIL model_cnt t=%0t got %0d want %0d", $time, chg_cnt, mcnt);
            end
            if (sr_err !== merr) begin
                errors++;
                $display("FAIL model_err t=%0t got %b want %b", $time, sr_err, merr);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic [3:0] jj,
                         input logic [3:0] kk, input logic ld, input logic [3:0] lv,
                         input logic c);
        en = e; mode = m; j = jj; k = kk;
        load = ld; load_val = lv; clr = c;
    endtask

    initial begin
        step();
        step();
        rst = 1'b1;
        armed = 1'b1;
        chk("rst_q", 8'(q), 8'b1010);
        drive(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
        step();
        chk("pre_load_q", 8'(q), 8'b0000);
        drive(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_q", 8'(q), 8'b1010);
        chk("async_qn", 8'(qn), 8'b0101);
        chk("async_cnt", 8'(chg_cnt), 8'd0);
        chk("async_err", 8'(sr_err), 8'd0);
        step();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("hold_q", 8'(q), 8'b1010);
            chk("hold_qchg", 8'(q_chg), 8'd0);
        end

        drive(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 0);
        step();
        drive(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 1);
        step();
        chk("jk_pre_cnt", 8'(chg_cnt), 8'd0);
        drive(1, 0, 4'b0011, 4'b0000, 0, 4'b0000, 0);
        step();
        chk("jk_set", 8'(q), 8'b0011);
        chk("jk_set_chg", 8'(q_chg), 8'd1);
        drive(1, 0, 4'b0000, 4'b0001, 0, 4'b0000, 0);
        step();
        chk("jk_clr", 8'(q), 8'b0010);
        chk("jk_clr_chg", 8'(q_chg), 8'd1);
        drive(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 0);
        step();
        chk("jk_tog", 8'(q), 8'b1101);
        chk("jk_tog_chg", 8'(q_chg), 8'd1);
        chk("jk_cnt", 8'(chg_cnt), 8'd3);

        drive(0, 0, 4'b0000, 4'b0000, 1, 4'b0101, 1);
        step();
        drive(1, 1, 4'b1100, 4'b0110, 0, 4'b0000, 0);
        step();
        chk("sr_q", 8'(q), 8'b1101);
        chk("sr_err_set", 8'(sr_err), 8'd1);
        drive(1, 1, 4'b0000, 4'b0001, 0, 4'b0000, 0);
        step();
        chk("sr_sticky", 8'(sr_err), 8'd1);
        chk("sr_legal_q", 8'(q), 8'b1100);
        drive(1, 1, 4'b0000, 4'b0000, 0, 4'b0000, 1);
        step();
        chk("sr_cleared", 8'(sr_err), 8'd0);
        drive(1, 1, 4'b1000, 4'b1000, 0, 4'b0000, 1);
        step();
        chk("sr_set_wins", 8'(sr_err), 8'd1);
        chk("sr_hold_q", 8'(q), 8'b1100);
        drive(0, 1, 4'b0000, 4'b0000, 0, 4'b0000, 1);
        step();

        drive(1, 0, 4'b1111, 4'b1111, 1, 4'b0111, 0);
        step();
        chk("load_q", 8'(q), 8'b0111);
        chk("load_chg", 8'(q_chg), 8'd1);
        chk("load_cnt", 8'(chg_cnt), 8'd1);
        drive(1, 1, 4'b1111, 4'b1111, 1, 4'b0111, 0);
        step();
        chk("reload_chg", 8'(q_chg), 8'd0);
        chk("reload_cnt", 8'(chg_cnt), 8'd1);
        chk("reload_noerr", 8'(sr_err), 8'd0);

        drive(0, 0, 4'b0000, 4'b0000, 1, 4'b0000, 1);
        step();
        drive(1, 2, 4'b1001, 4'b0110, 0, 4'b0000, 0);
        step();
        chk("t_first", 8'(q), 8'b1001);
        drive(1, 2, 4'b1001, 4'b1001, 0, 4'b0000, 0);
        step();
        chk("t_second", 8'(q), 8'b0000);
        drive(1, 3, 4'b0110, 4'b1111, 0, 4'b0000, 0);
        step();
        chk("d_q", 8'(q), 8'b0110);
        drive(1, 3, 4'b0110, 4'b0000, 0, 4'b0000, 0);
        step();
        chk("d_k_ignored", 8'(q), 8'b0110);

        drive(0, 2, 4'b0000, 4'b0000, 0, 4'b0000, 1);
        step();
        chk("sat_pre", 8'(chg_cnt), 8'd0);
        drive(1, 2, 4'b1111, 4'b0000, 0, 4'b0000, 0);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("sat_cnt", 8'(chg_cnt), (n < 3) ? 8'(n + 1) : 8'd3);
        end
        drive(1, 2, 4'b1111, 4'b0000, 0, 4'b0000, 1);
        step();
        chk("sat_clr_chg", 8'(chg_cnt), 8'd1);
        drive(0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
